// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_ctrl
// Description : Instruction fetch sequencer. Owns the program counter, drives
//               the combinational instruction ROM address and registers
//               {pc, instr} into a one-entry valid/ready output stage feeding
//               decode. Handles branch/jump redirects and halt requests.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous assert, synchronous release, active low
//   rom_addr       out  current PC driven to the ROM
//   rom_instr      in   ROM read data (combinational from rom_addr)
//   out_valid      out  output stage holds a valid instruction
//   out_ready      in   decode accepts the output stage this cycle
//   out_pc         out  PC of the held instruction
//   out_instr      out  held instruction
//   redirect_valid in   load redirect_pc, squash output stage, resume fetch
//   redirect_pc    in   redirect target (low two bits ignored)
//   halt_req       in   stop fetching after the current cycle
//   halted         out  fetch sequencer is halted
//   perf_fetched   out  (FETCH_PERF_EN) saturating count of accepted cycles
//   perf_stall     out  (FETCH_PERF_EN) saturating count of stalled cycles
// Build option:
//   FETCH_PERF_EN  adds the perf_fetched / perf_stall counter ports
// ============================================================================
module instr_fetch_ctrl #(
  parameter int unsigned                ADDRESS_WIDTH = 32,
  parameter int unsigned                DATA_WIDTH    = 32,
  parameter int unsigned                PC_STEP       = 4,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0]    out_instr,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  input  logic                     halt_req,
`ifdef FETCH_PERF_EN
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_stall,
`endif
  output logic                     halted
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] C_STEP     = ADDRESS_WIDTH'(PC_STEP);
  localparam logic [ADDRESS_WIDTH-1:0] C_ALIGN_MK = ~ADDRESS_WIDTH'(3);

  state_t                     state;
  logic [ADDRESS_WIDTH-1:0]   pc;

  assign rom_addr = pc;

  // Single sequential FSM; all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_instr <= '0;
      halted    <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect wins over everything, including a same-cycle accept or halt.
      state     <= FETCH;
      pc        <= redirect_pc & C_ALIGN_MK;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= FETCH;
          if (out_ready) out_valid <= 1'b0;
        end
        FETCH: begin
          if (halt_req) begin
            // No fetch this cycle; a held entry may still drain.
            state  <= HALTED;
            halted <= 1'b1;
            if (out_ready) out_valid <= 1'b0;
          end else if (!out_valid || out_ready) begin
            out_pc    <= pc;
            out_instr <= rom_instr;
            out_valid <= 1'b1;
            pc        <= pc + C_STEP;  // wraps modulo 2**ADDRESS_WIDTH
          end
        end
        HALTED: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
          state  <= BOOT;
          halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating performance counters on the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (out_valid && out_ready && (perf_fetched != 32'hFFFF_FFFF))
        perf_fetched <= perf_fetched + 32'd1;
      if (out_valid && !out_ready && (perf_stall != 32'hFFFF_FFFF))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_ctrl
// Description : Directed self-checking bench for instr_fetch_ctrl. Inputs are
//               driven and outputs sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] rom_addr;
  logic [31:0] rom_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_ctrl #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .PC_STEP       (4),
    .RESET_PC      (32'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_instr      (rom_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
`ifdef FETCH_PERF_EN
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
`endif
    .halted         (halted)
  );

  // ROM contents: two real instructions at 0 and 4, a tagged pattern elsewhere.
  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    if (a == 32'h0)      return 32'h0050_0093;
    else if (a == 32'h4) return 32'h00A0_0113;
    else                 return 32'hA500_0000 ^ a;
  endfunction

  assign rom_instr = rom_fn(rom_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle: cross a rising edge, land on the next falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;

    // ---------------- reset ----------------
    cyc(); cyc();
    check("rst_valid",  {63'd0, out_valid}, 64'd0);
    check("rst_addr",   {32'd0, rom_addr},  64'd0);
    check("rst_halted", {63'd0, halted},    64'd0);
    check("rst_outpc",  {32'd0, out_pc},    64'd0);
    check("rst_instr",  {32'd0, out_instr}, 64'd0);
`ifdef FETCH_PERF_EN
    check("rst_perf_f", {32'd0, perf_fetched}, 64'd0);
    check("rst_perf_s", {32'd0, perf_stall},   64'd0);
`endif
    rst_n = 1'b1;
    cyc();  // BOOT cycle: no fetch
    check("boot_addr",  {32'd0, rom_addr},  64'd0);
    check("boot_valid", {63'd0, out_valid}, 64'd0);

    // ---------------- streaming ----------------
    out_ready = 1'b1;
    cyc();
    check("s0_valid", {63'd0, out_valid}, 64'd1);
    check("s0_pc",    {32'd0, out_pc},    64'h0);
    check("s0_instr", {32'd0, out_instr}, 64'h0050_0093);
    check("s0_addr",  {32'd0, rom_addr},  64'h4);
    cyc();
    check("s1_pc",    {32'd0, out_pc},    64'h4);
    check("s1_instr", {32'd0, out_instr}, 64'h00A0_0113);
    check("s1_addr",  {32'd0, rom_addr},  64'h8);
    cyc();
    check("s2_pc",    {32'd0, out_pc},    64'h8);
    check("s2_instr", {32'd0, out_instr}, 64'hA500_0008);

    // ---------------- backpressure ----------------
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("bp_pc",    {32'd0, out_pc},    64'h8);
      check("bp_instr", {32'd0, out_instr}, 64'hA500_0008);
      check("bp_addr",  {32'd0, rom_addr},  64'hC);
      check("bp_valid", {63'd0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    cyc();
    check("bp_rel_pc",   {32'd0, out_pc},    64'hC);
    check("bp_rel_addr", {32'd0, rom_addr},  64'h10);

    // ---------------- halt / resume ----------------
    out_ready = 1'b0;
    halt_req  = 1'b1;
    cyc();
    check("h_halted", {63'd0, halted},    64'd1);
    check("h_addr",   {32'd0, rom_addr},  64'h10);
    check("h_valid",  {63'd0, out_valid}, 64'd1);
    check("h_pc",     {32'd0, out_pc},    64'hC);
    out_ready = 1'b1;  // halt_req stays high: no effect while halted
    cyc();
    check("h_drain",  {63'd0, out_valid}, 64'd0);
    check("h_addr2",  {32'd0, rom_addr},  64'h10);
    check("h_halt2",  {63'd0, halted},    64'd1);
    halt_req = 1'b0;
    cyc();
    check("h_addr3",  {32'd0, rom_addr},  64'h10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    cyc();
    check("res_halted", {63'd0, halted},    64'd0);
    check("res_addr",   {32'd0, rom_addr},  64'h20);
    check("res_valid",  {63'd0, out_valid}, 64'd0);
    redirect_valid = 1'b0;
    cyc();
    check("res_pc",     {32'd0, out_pc},    64'h20);
    check("res_vld2",   {63'd0, out_valid}, 64'd1);

    // ---------------- redirect squash with out_valid=1 ----------------
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    cyc();
    check("rd_valid", {63'd0, out_valid}, 64'd0);
    check("rd_addr",  {32'd0, rom_addr},  64'h40);
    redirect_valid = 1'b0;
    cyc();
    check("rd_pc",    {32'd0, out_pc},    64'h40);
    check("rd_instr", {32'd0, out_instr}, 64'hA500_0040);

    // ---------------- redirect beats halt ----------------
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    halt_req       = 1'b1;
    cyc();
    check("pri_halted", {63'd0, halted},   64'd0);
    check("pri_addr",   {32'd0, rom_addr}, 64'h80);
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
    cyc();
    check("pri_pc",     {32'd0, out_pc},    64'h80);
    check("pri_valid",  {63'd0, out_valid}, 64'd1);

    // ---------------- pc wrap ----------------
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    check("wr_pc0",   {32'd0, out_pc},    64'hFFFF_FFFC);
    check("wr_addr0", {32'd0, rom_addr},  64'h0);
    cyc();
    check("wr_pc1",   {32'd0, out_pc},    64'h0);
    check("wr_instr", {32'd0, out_instr}, 64'h0050_0093);

    // ---------------- mid-operation reset ----------------
    #1 rst_n = 1'b0;
    #1;
    check("mr_valid",  {63'd0, out_valid}, 64'd0);
    check("mr_addr",   {32'd0, rom_addr},  64'd0);
    check("mr_outpc",  {32'd0, out_pc},    64'd0);
    check("mr_halted", {63'd0, halted},    64'd0);
    out_ready = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();  // BOOT

`ifdef FETCH_PERF_EN
    // ---------------- perf: 2 stalls + 5 accepts ----------------
    check("pf_zero", {32'd0, perf_fetched}, 64'd0);
    out_ready = 1'b0;
    cyc();  // first load (out_valid was 0)
    cyc();  // stall 1
    cyc();  // stall 2
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    check("pf_fetched", {32'd0, perf_fetched}, 64'd5);
    check("pf_stall",   {32'd0, perf_stall},   64'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
